// File: rtl/updown_autorepeat_ctrl.sv
// Up/down key sequencer: one step per press, then auto-repeat while held.
// Arbitrates conflicting keys, applies wrap/saturate limits, holds the count.
module updown_autorepeat_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MAXVAL = 15,
    parameter bit          WRAP   = 1'b1,
    parameter int unsigned DLY    = 12_500_000,
    parameter int unsigned RATE   = 2_500_000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_key_up,
    input  logic             i_key_dn,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_step_up,
    output logic             o_step_dn,
    output logic             o_at_max,
    output logic             o_at_min,
    output logic             o_busy
);

    localparam int unsigned TMAX = (DLY > RATE) ? DLY : RATE;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT,
        ST_LOCK
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_nx;
    logic             r_dir;
    logic             w_dir_nx;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nx;
    logic             r_step_up;
    logic             r_step_dn;
    logic             w_step_up_nx;
    logic             w_step_dn_nx;
    logic             w_step;
    logic             w_step_dir;
    logic             w_req_up;
    logic             w_req_dn;
    logic             w_req;
    logic             w_any_key;
    logic [WIDTH-1:0] w_cnt_max;

    // Conflicting keys cancel; dir 1 = up.
    assign w_req_up  = i_key_up & ~i_key_dn;
    assign w_req_dn  = i_key_dn & ~i_key_up;
    assign w_req     = w_req_up | w_req_dn;
    assign w_any_key = i_key_up | i_key_dn;
    assign w_cnt_max = WIDTH'(MAXVAL);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_dir     <= 1'b0;
            r_cnt     <= '0;
            r_step_up <= 1'b0;
            r_step_dn <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_timer   <= w_timer_nx;
            r_dir     <= w_dir_nx;
            r_cnt     <= w_cnt_nx;
            r_step_up <= w_step_up_nx;
            r_step_dn <= w_step_dn_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_timer_nx   = r_timer;
        w_dir_nx     = r_dir;
        w_cnt_nx     = r_cnt;
        w_step       = 1'b0;
        w_step_dir   = r_dir;
        w_step_up_nx = 1'b0;
        w_step_dn_nx = 1'b0;

        // Clear wins everywhere; a key still down must be released before the next press.
        if (i_clr) begin
            w_cnt_nx   = '0;
            w_timer_nx = '0;
            w_state_nx = w_any_key ? ST_LOCK : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        w_step     = 1'b1;
                        w_step_dir = w_req_up;
                        w_dir_nx   = w_req_up;
                        w_timer_nx = TW'(DLY - 1);
                        w_state_nx = ST_DELAY;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (!w_req || (w_req_up != r_dir)) begin
                        w_state_nx = ST_IDLE;
                    end else if (r_timer != '0) begin
                        w_timer_nx = r_timer - TW'(1);
                    end else begin
                        w_step     = 1'b1;
                        w_step_dir = r_dir;
                        w_timer_nx = TW'(RATE - 1);
                        w_state_nx = ST_REPEAT;
                    end
                end
                ST_LOCK: begin
                    if (!w_any_key) begin
                        w_state_nx = ST_IDLE;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase

            // Limits: wrap pulses as a normal step, saturate leaves count and pulses quiet.
            if (w_step) begin
                if (w_step_dir) begin
                    if (r_cnt != w_cnt_max) begin
                        w_cnt_nx     = r_cnt + WIDTH'(1);
                        w_step_up_nx = 1'b1;
                    end else if (WRAP) begin
                        w_cnt_nx     = '0;
                        w_step_up_nx = 1'b1;
                    end
                end else begin
                    if (r_cnt != '0) begin
                        w_cnt_nx     = r_cnt - WIDTH'(1);
                        w_step_dn_nx = 1'b1;
                    end else if (WRAP) begin
                        w_cnt_nx     = w_cnt_max;
                        w_step_dn_nx = 1'b1;
                    end
                end
            end
        end
    end

    assign o_cnt     = r_cnt;
    assign o_step_up = r_step_up;
    assign o_step_dn = r_step_dn;
    assign o_at_max  = (r_cnt == w_cnt_max);
    assign o_at_min  = (r_cnt == '0);
    assign o_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_updown_autorepeat_ctrl.sv
// Bench: a wrapping and a saturating instance share stimulus; expected outputs
// are queued per edge and compared against both instances.
module tb_updown_autorepeat_ctrl;

    localparam int unsigned W    = 4;
    localparam int unsigned MX   = 9;
    localparam int unsigned DLY  = 4;
    localparam int unsigned RATE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         key_up;
    logic         key_dn;
    logic         clr;
    logic [W-1:0] a_cnt;
    logic         a_su, a_sd, a_amax, a_amin, a_busy;
    logic [W-1:0] b_cnt;
    logic         b_su, b_sd, b_amax, b_amin, b_busy;

    updown_autorepeat_ctrl #(
        .WIDTH(W), .MAXVAL(MX), .WRAP(1'b1), .DLY(DLY), .RATE(RATE)
    ) dut_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_key_up(key_up), .i_key_dn(key_dn), .i_clr(clr),
        .o_cnt(a_cnt), .o_step_up(a_su), .o_step_dn(a_sd),
        .o_at_max(a_amax), .o_at_min(a_amin), .o_busy(a_busy)
    );

    updown_autorepeat_ctrl #(
        .WIDTH(W), .MAXVAL(MX), .WRAP(1'b0), .DLY(DLY), .RATE(RATE)
    ) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_key_up(key_up), .i_key_dn(key_dn), .i_clr(clr),
        .o_cnt(b_cnt), .o_step_up(b_su), .o_step_dn(b_sd),
        .o_at_max(b_amax), .o_at_min(b_amin), .o_busy(b_busy)
    );

    typedef struct packed {
        logic [W-1:0] a_cnt;
        logic         a_su;
        logic         a_sd;
        logic [W-1:0] b_cnt;
        logic         b_su;
        logic         b_sd;
        logic         busy;
    } exp_t;

    exp_t  q[$];
    string tq[$];
    int    total = 0;
    int    bad   = 0;

    // Reference count and pulses for the wrapping (a) and saturating (b) instance.
    int   ea = 0;
    int   eb = 0;
    logic pa_u = 1'b0, pa_d = 1'b0, pb_u = 1'b0, pb_d = 1'b0;

    task automatic model_step(input bit up);
        if (up) begin
            ea   = (ea == int'(MX)) ? 0 : ea + 1;
            pa_u = 1'b1;
            if (eb != int'(MX)) begin
                eb   = eb + 1;
                pb_u = 1'b1;
            end
        end else begin
            ea   = (ea == 0) ? int'(MX) : ea - 1;
            pa_d = 1'b1;
            if (eb != 0) begin
                eb   = eb - 1;
                pb_d = 1'b1;
            end
        end
    endtask

    task automatic push(input string tag, input logic busy);
        exp_t e;
        e.a_cnt = W'(ea);
        e.a_su  = pa_u;
        e.a_sd  = pa_d;
        e.b_cnt = W'(eb);
        e.b_su  = pb_u;
        e.b_sd  = pb_d;
        e.busy  = busy;
        q.push_back(e);
        tq.push_back(tag);
    endtask

    task automatic check_one(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_compare();
        exp_t  e;
        string t;
        e = q.pop_front();
        t = tq.pop_front();
        check_one({t, ".a_cnt"},  a_cnt,      e.a_cnt);
        check_one({t, ".a_su"},   W'(a_su),   W'(e.a_su));
        check_one({t, ".a_sd"},   W'(a_sd),   W'(e.a_sd));
        check_one({t, ".a_amax"}, W'(a_amax), W'(e.a_cnt == W'(MX)));
        check_one({t, ".a_amin"}, W'(a_amin), W'(e.a_cnt == '0));
        check_one({t, ".a_busy"}, W'(a_busy), W'(e.busy));
        check_one({t, ".b_cnt"},  b_cnt,      e.b_cnt);
        check_one({t, ".b_su"},   W'(b_su),   W'(e.b_su));
        check_one({t, ".b_sd"},   W'(b_sd),   W'(e.b_sd));
        check_one({t, ".b_amax"}, W'(b_amax), W'(e.b_cnt == W'(MX)));
        check_one({t, ".b_amin"}, W'(b_amin), W'(e.b_cnt == '0));
        check_one({t, ".b_busy"}, W'(b_busy), W'(e.busy));
    endtask

    // One active edge with inputs as currently driven, then compare.
    task automatic tick_chk(input string tag, input logic busy);
        push(tag, busy);
        @(posedge clk);
        #1;
        pop_compare();
        pa_u = 1'b0; pa_d = 1'b0; pb_u = 1'b0; pb_d = 1'b0;
    endtask

    // Hold one key for n edges; steps land at e0, e0+DLY, then every RATE.
    task automatic hold(input bit up, input int n, input string tag);
        key_up = up;
        key_dn = !up;
        for (int k = 0; k < n; k++) begin
            if (k == 0 || (k >= int'(DLY) && ((k - int'(DLY)) % int'(RATE)) == 0))
                model_step(up);
            tick_chk(tag, 1'b1);
        end
    endtask

    task automatic tap(input bit up, input string tag);
        key_up = up;
        key_dn = !up;
        model_step(up);
        tick_chk(tag, 1'b1);
        key_up = 1'b0;
        key_dn = 1'b0;
        tick_chk({tag, "_rel"}, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        key_up = 1'b0;
        key_dn = 1'b0;
        clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push("reset", 1'b0);
        pop_compare();
        rst_n = 1'b1;
        tick_chk("idle_after_reset", 1'b0);

        // Single tap from zero: one step, then back to idle and quiet.
        tap(1'b1, "tap_up");
        tick_chk("idle_quiet", 1'b0);

        // Clear with keys up goes straight to idle.
        clr = 1'b1;
        ea = 0; eb = 0;
        tick_chk("clr_idle", 1'b0);
        clr = 1'b0;

        // Held up key: steps at e0,e4,e6,e8,e10 -> 5.
        hold(1'b1, 11, "hold_up");
        key_up = 1'b0;
        tick_chk("hold_rel", 1'b0);

        // Both keys: no request; dropping down key makes a fresh up press.
        key_up = 1'b1;
        key_dn = 1'b1;
        for (int i = 0; i < 10; i++) tick_chk("both_keys", 1'b0);
        key_dn = 1'b0;
        model_step(1'b1);
        tick_chk("both_drop_dn", 1'b1);
        key_up = 1'b0;
        tick_chk("both_rel", 1'b0);

        // Clear while down held: lock with no steps until release.
        key_dn = 1'b1;
        clr    = 1'b1;
        ea = 0; eb = 0;
        tick_chk("clr_lock", 1'b1);
        clr = 1'b0;
        for (int i = 0; i < 5; i++) tick_chk("lock_hold", 1'b1);
        key_dn = 1'b0;
        tick_chk("lock_rel", 1'b0);

        // Down from zero: wrap to MAXVAL vs. saturate at zero.
        tap(1'b0, "tap_dn_at_min");

        // Up from MAXVAL (wrap instance), then run both up to the top.
        tap(1'b1, "tap_up_wrap");
        hold(1'b1, 17, "hold_up_long");
        key_up = 1'b0;
        tick_chk("hold_long_rel", 1'b0);
        tap(1'b1, "tap_up_to_max");
        tap(1'b1, "tap_up_at_max");

        // Async reset in the middle of repeating at count 7.
        hold(1'b1, 16, "hold_before_rst");
        #2;
        rst_n = 1'b0;
        #1;
        ea = 0; eb = 0;
        pa_u = 1'b0; pa_d = 1'b0; pb_u = 1'b0; pb_d = 1'b0;
        push("rst_async", 1'b0);
        pop_compare();
        key_up = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick_chk("after_rst_quiet", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
